// File: rtl/cti_commit_reader_pkg.sv
// Shared types and constants for the CTI commit RAM drain path.
package cti_commit_reader_pkg;

    localparam int unsigned COMMIT_WIDTH = 4;
    localparam int unsigned MAX_COMMIT   = COMMIT_WIDTH + 1;
    localparam int unsigned CTI_WIDTH    = 8;

    typedef logic [CTI_WIDTH-1:0] cti_rec_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_STREAM = 2'd1,
        ST_HOLD   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/cti_occupancy_ctr.sv
// Occupancy counter for the CTI commit RAM: saturating count, sticky overflow, commit stall.
module cti_occupancy_ctr
    import cti_commit_reader_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned INDEX     = 4,
    parameter int unsigned MAXCOMMIT = MAX_COMMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       commit_cnt,
    input  logic             pop,
    output logic [INDEX:0]   count,
    output logic             stall,
    output logic             overflow
);

    localparam int unsigned SW = INDEX + 2;

    logic [SW-1:0] sum;

    // One extra bit so that count + commit_cnt can exceed DEPTH and be detected.
    always_comb begin
        sum = SW'(count) + SW'(commit_cnt) - SW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (sum > SW'(DEPTH)) begin
            count    <= (INDEX+1)'(DEPTH);
            overflow <= 1'b1;
        end else begin
            count <= sum[INDEX:0];
        end
    end

    assign stall = (count > (INDEX+1)'(DEPTH - MAXCOMMIT));

endmodule

// File: rtl/cti_commit_reader.sv
// Drains the CTI commit RAM in order to the predictor update port.
// Optional drain statistics counter enabled by CTI_READER_STATS_EN.
module cti_commit_reader
    import cti_commit_reader_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned INDEX     = 4,
    parameter int unsigned WIDTH     = CTI_WIDTH,
    parameter int unsigned MAXCOMMIT = MAX_COMMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       commitCnt_i,
    output logic [INDEX-1:0] ramAddr_o,
    input  logic [WIDTH-1:0] ramData_i,
    output logic             updValid_o,
    output logic [WIDTH-1:0] updData_o,
    input  logic             updReady_i,
    output logic             stall_o,
    output logic             overflow_o
`ifdef CTI_READER_STATS_EN
    ,
    output logic [31:0]      drainCnt_o
`endif
);

    logic [INDEX-1:0] rd_ptr;
    logic [INDEX:0]   count;
    logic             pop;
    rd_state_t        state;
    rd_state_t        state_nxt;

    cti_occupancy_ctr #(
        .DEPTH     (DEPTH),
        .INDEX     (INDEX),
        .MAXCOMMIT (MAXCOMMIT)
    ) u_occ (
        .clk        (clk),
        .reset      (reset),
        .commit_cnt (commitCnt_i),
        .pop        (pop),
        .count      (count),
        .stall      (stall_o),
        .overflow   (overflow_o)
    );

    assign ramAddr_o  = rd_ptr;
    // The valid flag is the registered FSM state itself.
    assign updValid_o = (state != ST_EMPTY);
    assign pop        = (count != '0) && (!updValid_o || updReady_i);

    always_comb begin
        state_nxt = state;
        if (pop) begin
            state_nxt = ST_STREAM;
        end else if (updValid_o && !updReady_i) begin
            state_nxt = ST_HOLD;
        end else begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            rd_ptr    <= '0;
            updData_o <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                updData_o <= ramData_i;
                rd_ptr    <= rd_ptr + INDEX'(1);
            end
        end
    end

`ifdef CTI_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drainCnt_o <= '0;
        end else if (updValid_o && updReady_i) begin
            drainCnt_o <= drainCnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cti_commit_reader.sv
// Scoreboard bench for cti_commit_reader with a behavioural commit RAM.
module tb_cti_commit_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  commit_cnt;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        upd_valid;
    logic [7:0]  upd_data;
    logic        upd_ready;
    logic        stall;
    logic        overflow;
`ifdef CTI_READER_STATS_EN
    logic [31:0] drain_cnt;
`endif

    logic [7:0]  mem [16];
    logic [7:0]  exp_q [$];
    int          wr_ptr;
    logic [7:0]  next_val;
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    assign ram_data = mem[ram_addr];

    cti_commit_reader #(
        .DEPTH     (16),
        .INDEX     (4),
        .WIDTH     (8),
        .MAXCOMMIT (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .commitCnt_i (commit_cnt),
        .ramAddr_o   (ram_addr),
        .ramData_i   (ram_data),
        .updValid_o  (upd_valid),
        .updData_o   (upd_data),
        .updReady_i  (upd_ready),
        .stall_o     (stall),
        .overflow_o  (overflow)
`ifdef CTI_READER_STATS_EN
        ,
        .drainCnt_o  (drain_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commit writes land in the RAM at the end of this cycle.
    task automatic do_commit(input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr] = next_val;
            exp_q.push_back(next_val);
            wr_ptr   = (wr_ptr + 1) % 16;
            next_val = next_val + 8'd1;
        end
        commit_cnt = 3'(n);
        tick();
        commit_cnt = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        wr_ptr = 0;
    endtask

    always @(negedge clk) begin
        if (!reset && upd_valid && upd_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious", 32'(upd_data), 32'hFFFF_FFFF);
            end else begin
                check("sb_data", 32'(upd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        wr_ptr     = 0;
        next_val   = 8'h10;
        commit_cnt = '0;
        upd_ready  = 1'b1;
        reset      = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tick();
        do_reset();

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            check("idle_valid", 32'(upd_valid), 0);
            check("idle_addr", 32'(ram_addr), 0);
            check("idle_stall", 32'(stall), 0);
            tick();
        end
        check("idle_ovf", 32'(overflow), 0);
        check("idle_data", 32'(upd_data), 0);

        // Burst of 4: 0x10..0x13 on cycles N+2..N+5
        do_commit(4);
        check("burst_lat", 32'(upd_valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("burst_valid", 32'(upd_valid), 1);
            check("burst_data", 32'(upd_data), 32'h10 + 32'(k));
        end
        tick();
        check("burst_end", 32'(upd_valid), 0);
        check("burst_addr", 32'(ram_addr), 4);

        // Back-pressure on the second record of 0x14..0x17
        do_commit(4);
        tick();
        check("bp_first", 32'(upd_data), 32'h14);
        tick();
        upd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", 32'(upd_valid), 1);
            check("bp_stable", 32'(upd_data), 32'h15);
            check("bp_addr", 32'(ram_addr), 6);
            tick();
        end
        check("bp_held", 32'(upd_data), 32'h15);
        upd_ready = 1'b1;
        tick();
        check("bp_next_valid", 32'(upd_valid), 1);
        check("bp_next_data", 32'(upd_data), 32'h16);
        tick();
        tick();
        check("bp_drained", 32'(upd_valid), 0);
        check("bp_addr_end", 32'(ram_addr), 8);

        // Advance to rdPtr = 14, then wrap
        do_commit(5);
        do_commit(1);
        repeat (8) tick();
        check("wrap_start", 32'(ram_addr), 14);
        do_commit(4);
        for (int k = 0; k < 4; k++) begin
            check("wrap_addr", 32'(ram_addr), 32'((14 + k) % 16));
            tick();
            check("wrap_nobubble", 32'(upd_valid), 1);
        end
        check("wrap_addr_end", 32'(ram_addr), 2);
        tick();
        check("wrap_end", 32'(upd_valid), 0);

        // Stall threshold and overflow with the predictor blocked
        upd_ready = 1'b0;
        do_commit(5);
        do_commit(5);
        do_commit(2);
        check("stall_at_11", 32'(stall), 0);
        do_commit(1);
        check("stall_at_12", 32'(stall), 1);
        check("no_ovf_yet", 32'(overflow), 0);
        do_commit(5);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(dut.u_occ.count), 16);
        check("ovf_stall", 32'(stall), 1);
        repeat (3) tick();
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_count_hold", 32'(dut.u_occ.count), 16);
        do_reset();
        upd_ready = 1'b1;
        check("rst_ovf", 32'(overflow), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_addr", 32'(ram_addr), 0);

`ifdef CTI_READER_STATS_EN
        do_commit(5);
        do_commit(2);
        repeat (8) tick();
        check("stats_7", drain_cnt, 7);
`endif

        // Reset mid-stream discards everything
        do_commit(4);
        tick();
        tick();
        check("mid_valid", 32'(upd_valid), 1);
        do_reset();
        check("mid_rst_valid", 32'(upd_valid), 0);
        check("mid_rst_data", 32'(upd_data), 0);
        check("mid_rst_addr", 32'(ram_addr), 0);
`ifdef CTI_READER_STATS_EN
        check("mid_rst_stats", drain_cnt, 0);
`endif
        tick();
        check("mid_rst_idle", 32'(upd_valid), 0);

        // Normal operation resumes from address 0
        do_commit(3);
        repeat (6) tick();
        check("sb_empty", 32'(exp_q.size()), 0);
        check("final_addr", 32'(ram_addr), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
